// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl
//   Turns a bouncy step pushbutton or a divided slow clock into single-cycle
//   advance strobes for a pipelined CPU. Three modes:
//     STEP (00): one strobe per debounced button press
//     RUN  (01): one strobe per rising edge of slowTick
//     HALT (10): no strobes; left only through reset
//   Ports:
//     clockIn    - board clock, all state on its rising edge
//     reset      - asynchronous, active-high
//     slowTick   - divided clock level (clockIn domain)
//     stepButton - raw pushbutton (asynchronous)
//     runSwitch  - raw slide switch (asynchronous), 1 = run, 0 = step
//     haltReq    - synchronous halt request from the CPU
//     cpuEnable  - registered one-cycle advance strobe
//     cycleCount - strobes issued since reset, wraps at 2^32
//     mode       - current FSM state for the LEDs
module step_clock_ctrl #(
  parameter int DEBOUNCE_LEN = 500000
) (
  input  logic        clockIn,
  input  logic        reset,
  input  logic        slowTick,
  input  logic        stepButton,
  input  logic        runSwitch,
  input  logic        haltReq,
  output logic        cpuEnable,
  output logic [31:0] cycleCount,
  output logic [1:0]  mode
);

  localparam logic [19:0] LAST_CNT = 20'(DEBOUNCE_LEN - 1);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // Two-flop synchronizers for the asynchronous board inputs
  logic [1:0] r_btn_sync;
  logic [1:0] r_run_sync;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_btn_sync <= 2'b00;
      r_run_sync <= 2'b00;
    end else begin
      r_btn_sync <= {r_btn_sync[0], stepButton};
      r_run_sync <= {r_run_sync[0], runSwitch};
    end
  end

  logic w_btn_s;
  logic w_run_s;
  assign w_btn_s = r_btn_sync[1];
  assign w_run_s = r_run_sync[1];

  // Debouncer: counts consecutive cycles the synchronized button disagrees
  // with the accepted level; flips the level on the cycle the count would
  // reach DEBOUNCE_LEN.
  logic        r_db_level;
  logic [19:0] r_db_cnt;
  logic        w_db_flip;
  logic        w_step_edge;

  assign w_db_flip   = (w_btn_s != r_db_level) && (r_db_cnt == LAST_CNT);
  assign w_step_edge = w_db_flip && !r_db_level;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
    end else if (w_btn_s == r_db_level) begin
      r_db_cnt   <= '0;
    end else if (w_db_flip) begin
      r_db_level <= ~r_db_level;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt   <= r_db_cnt + 20'd1;
    end
  end

  // Rising-edge detect on slowTick. r_tick_armed stays low until slowTick
  // has been seen low once after reset, so a tick already high at release
  // cannot masquerade as an edge.
  logic r_slow_q;
  logic r_tick_armed;
  logic w_tick_edge;

  assign w_tick_edge = slowTick && !r_slow_q && r_tick_armed;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_slow_q     <= 1'b0;
      r_tick_armed <= 1'b0;
    end else begin
      r_slow_q     <= slowTick;
      r_tick_armed <= r_tick_armed | ~slowTick;
    end
  end

  // Mode FSM with registered strobe. The strobe is decided by the state
  // before any transition; the ~r_cpu_enable term keeps a STEP->RUN switch
  // from producing back-to-back strobes.
  state_t r_state;
  logic   r_cpu_enable;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_state      <= ST_STEP;
      r_cpu_enable <= 1'b0;
    end else begin
      r_cpu_enable <= 1'b0;
      case (r_state)
        ST_STEP: begin
          if (haltReq) begin
            r_state <= ST_HALT;
          end else begin
            r_cpu_enable <= w_step_edge && !r_cpu_enable;
            if (w_run_s) r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (haltReq) begin
            r_state <= ST_HALT;
          end else begin
            r_cpu_enable <= w_tick_edge && !r_cpu_enable;
            if (!w_run_s) r_state <= ST_STEP;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  logic [31:0] r_cycle_count;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset)             r_cycle_count <= '0;
    else if (r_cpu_enable) r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign cpuEnable  = r_cpu_enable;
  assign cycleCount = r_cycle_count;
  assign mode       = r_state;

endmodule
